// File: rtl/fifo_flex.sv
// fifo_flex: synchronous first-word-fall-through FIFO with arbitrary depth.
// It provides a registered occupancy count, almost-full/almost-empty thresholds,
// a synchronous flush, and sticky overflow/underflow flags.
//
// Handshake: push and pop are request strobes sampled on the rising clk edge.
// A pop is accepted only when the FIFO is not empty. A push is accepted when
// the FIFO is not full, or when it is full and an accepted pop frees a slot on
// the same edge. A rejected request sets the matching sticky error flag. flush
// overrides both requests for that cycle.
module fifo_flex #(
  parameter int DW        = 32,
  parameter int DEPTH     = 6,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] write_data,
  input  logic          pop,
  output logic [DW-1:0] read_data,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [CW-1:0] count,
  input  logic          err_clr,
  output logic          overflow,
  output logic          underflow
);

  // Pointer width: enough bits to index DEPTH entries (DEPTH >= 2, so >= 1 bit).
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AF_THRESH);
  localparam logic [CW-1:0] CNT_AE   = CW'(AE_THRESH);

  // Parameter legality is rejected at elaboration time.
  if (DEPTH < 2) begin : g_chk_depth
    $error("fifo_flex: DEPTH must be at least 2");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_chk_af
    $error("fifo_flex: AF_THRESH must be in 1..DEPTH");
  end
  if ((AE_THRESH < 0) || (AE_THRESH >= DEPTH)) begin : g_chk_ae
    $error("fifo_flex: AE_THRESH must be in 0..DEPTH-1");
  end

  logic [DW-1:0] mem_q [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic pop_acc, push_acc;
  logic wr_en, rd_en;
  logic ovf_evt, udf_evt;

  // Status flags come straight from the registered count.
  assign empty        = (count_q == '0);
  assign full         = (count_q == CNT_FULL);
  assign almost_full  = (count_q >= CNT_AF);
  assign almost_empty = (count_q <= CNT_AE);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // FWFT head word; reads as zero while empty so no stale data leaks out.
  assign read_data = empty ? '0 : mem_q[rd_ptr_q];

  // Acceptance decisions. A full FIFO still takes a push when a pop frees the
  // slot on the same edge. An empty FIFO never bypasses a push to a pop.
  always_comb begin
    pop_acc  = pop & ~empty;
    push_acc = push & (~full | pop_acc);
    wr_en    = ~flush & push_acc;
    rd_en    = ~flush & pop_acc;
    ovf_evt  = ~flush & push & ~push_acc;
    udf_evt  = ~flush & pop & ~pop_acc;
  end

  // Next-state logic for the pointers, count and sticky error flags.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // The pointers wrap explicitly, because DEPTH need not be a power of two.
      if (wr_en) begin
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
      count_d = count_q + {{(CW-1){1'b0}}, wr_en} - {{(CW-1){1'b0}}, rd_en};
    end

    // A clear and a new error on the same edge leave the flag set.
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (ovf_evt) overflow_d  = 1'b1;
    if (udf_evt) underflow_d = 1'b1;
  end

  // Control state register with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array write port. The contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= write_data;
    end
  end

endmodule

// File: tb/tb_fifo_flex.sv
// Directed testbench for fifo_flex (DW=16, DEPTH=5, AF=4, AE=1).
module tb_fifo_flex;

  localparam int DW = 16;
  localparam int DEPTH = 5;
  localparam int CW = $clog2(DEPTH + 1);

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          flush = 1'b0;
  logic          push = 1'b0;
  logic [DW-1:0] write_data = '0;
  logic          pop = 1'b0;
  logic [DW-1:0] read_data;
  logic          full, empty, almost_full, almost_empty;
  logic [CW-1:0] count;
  logic          err_clr = 1'b0;
  logic          overflow, underflow;

  fifo_flex #(
    .DW(DW), .DEPTH(DEPTH), .AF_THRESH(4), .AE_THRESH(1)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push(push), .write_data(write_data), .pop(pop),
    .read_data(read_data), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .err_clr(err_clr),
    .overflow(overflow), .underflow(underflow)
  );

  // Scoreboard
  int n_checks = 0;
  int n_pass = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Driver: present one cycle of requests, clock it, and sample #1 after the edge.
  task automatic step(input logic p, input logic [DW-1:0] d, input logic q,
                      input logic f, input logic c);
    push = p; write_data = d; pop = q; flush = f; err_clr = c;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; flush = 1'b0; err_clr = 1'b0; write_data = '0;
  endtask

  task automatic check_flags(input string tag, input int cnt);
    check({tag, ".count"}, 32'(count), 32'(cnt));
    check({tag, ".empty"}, 32'(empty), 32'(cnt == 0));
    check({tag, ".full"}, 32'(full), 32'(cnt == 5));
    check({tag, ".af"}, 32'(almost_full), 32'(cnt >= 4));
    check({tag, ".ae"}, 32'(almost_empty), 32'(cnt <= 1));
  endtask

  initial begin
    logic [DW-1:0] head;

    // Check the reset state while rst is held.
    #2;
    check_flags("rst", 0);
    check("rst.ovf", 32'(overflow), 0);
    check("rst.udf", 32'(underflow), 0);
    check("rst.rdata", 32'(read_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Fill 0x0001..0x0005; the head stays at 0x0001.
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
      exp_q.push_back(DW'(i));
      check_flags($sformatf("fill%0d", i), i);
      check($sformatf("fill%0d.rdata", i), 32'(read_data), 32'h0001);
    end

    // Push and pop together while full: 0x0001 leaves, 0xAAAA enters.
    step(1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    exp_q.push_back(16'hAAAA);
    check_flags("fullpp", 5);
    check("fullpp.ovf", 32'(overflow), 0);
    check("fullpp.rdata", 32'(read_data), 32'h0002);

    // Push while full without a pop: the push is rejected.
    step(1'b1, 16'hBBBB, 1'b0, 1'b0, 1'b0);
    check("ovf.flag", 32'(overflow), 1);
    check("ovf.count", 32'(count), 5);
    check("ovf.rdata", 32'(read_data), 32'h0002);

    // Drain the FIFO and compare each head word against the scoreboard.
    for (int i = 0; i < 5; i++) begin
      head = exp_q.pop_front();
      check($sformatf("drain%0d", i), 32'(read_data), 32'(head));
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    check_flags("drained", 0);
    check("drained.rdata", 32'(read_data), 0);

    // Pop while empty: the pop is rejected.
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("udf.flag", 32'(underflow), 1);
    check("udf.rdata", 32'(read_data), 0);
    check("udf.count", 32'(count), 0);

    // Assert err_clr: both error flags clear.
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("clr.ovf", 32'(overflow), 0);
    check("clr.udf", 32'(underflow), 0);

    // Refill, overflow, then err_clr together with a new overflow.
    for (int i = 0; i < 5; i++) step(1'b1, DW'(16'h0011 + i), 1'b0, 1'b0, 1'b0);
    check_flags("refill", 5);
    step(1'b1, 16'hCCCC, 1'b0, 1'b0, 1'b0);
    check("ovf2.flag", 32'(overflow), 1);
    step(1'b1, 16'hDDDD, 1'b0, 1'b0, 1'b1);
    check("clrovf.ovf", 32'(overflow), 1);
    check("clrovf.count", 32'(count), 5);
    check("clrovf.rdata", 32'(read_data), 32'h0011);

    // Flush from full: the error flags are kept.
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check_flags("flush1", 0);
    check("flush1.ovf", 32'(overflow), 1);

    // Fill to 3, then flush together with a push.
    for (int i = 0; i < 3; i++) step(1'b1, DW'(16'h0021 + i), 1'b0, 1'b0, 1'b0);
    check_flags("fill3", 3);
    step(1'b1, 16'h7777, 1'b0, 1'b1, 1'b0);
    check_flags("flushpush", 0);
    check("flushpush.ovf", 32'(overflow), 1);
    check("flushpush.udf", 32'(underflow), 0);
    check("flushpush.rdata", 32'(read_data), 0);
    step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    check("postflush.rdata", 32'(read_data), 32'h1234);
    check_flags("postflush", 1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check_flags("postflush.pop", 0);

    // Run interleaved push/pop pairs so the pointers wrap several times.
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, DW'(16'h0100 + i), (i > 0), 1'b0, 1'b0);
      if (i > 0) void'(exp_q.pop_front());
      exp_q.push_back(DW'(16'h0100 + i));
      check($sformatf("wrap%0d.rdata", i), 32'(read_data), 32'(exp_q[0]));
      check($sformatf("wrap%0d.count", i), 32'(count), 1);
    end
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check_flags("wrap.end", 0);

    // Set underflow again, then stop at count 4.
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("udf2.flag", 32'(underflow), 1);
    for (int i = 0; i < 4; i++) step(1'b1, DW'(16'h0031 + i), 1'b0, 1'b0, 1'b0);
    check_flags("pre_arst", 4);
    check("pre_arst.ovf", 32'(overflow), 1);

    // Assert rst between clock edges: the state clears before the next edge.
    #2;
    rst = 1'b1;
    #1;
    check_flags("arst", 0);
    check("arst.ovf", 32'(overflow), 0);
    check("arst.udf", 32'(underflow), 0);
    check("arst.rdata", 32'(read_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Normal operation after reset.
    step(1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b0);
    check("post_rst.rdata", 32'(read_data), 32'h5A5A);
    check_flags("post_rst", 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_flex.md
Name: fifo_flex

Overview:
- Next-generation synchronous FIFO for buffering coefficient/twiddle streams between NTT pipeline stages.
- Supports arbitrary (non-power-of-two) depth.
- Adds a registered occupancy count, programmable almost-full/almost-empty flags, synchronous flush, and sticky overflow/underflow error flags.
- Read data is first-word-fall-through.

Parameters:
- DW, 32, data word width in bits (>=1).
- DEPTH, 6, number of storage entries (>=2, any integer).
- AF_THRESH, DEPTH-1, almost_full asserts when count >= AF_THRESH (1..DEPTH).
- AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1).
- CW (localparam), $clog2(DEPTH+1), width of count.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of contents and pointers.
- push  in  1  write request.
- write_data  in  DW  data written on accepted push.
- pop  in  1  read request; consumes the word on read_data.
- read_data  out  DW  head-of-queue word (FWFT).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  CW  current occupancy, 0..DEPTH.
- err_clr  in  1  synchronous clear of the sticky error flags.
- overflow  out  1  sticky: a push was rejected.
- underflow  out  1  sticky: a pop was rejected.

Behaviour:
- One clock domain (clk); reset is asynchronous and active-high (rst).
- Reset: rd_ptr=wr_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0 (AF_THRESH>=1), overflow=0, underflow=0, read_data=0. Memory contents are not reset.
- Reset asserted mid-operation immediately clears all state above, independent of clk.
- Pointers are binary 0..DEPTH-1. They wrap DEPTH-1 -> 0 explicitly, with no power-of-two masking.
- pop_acc = pop & ~empty.
- push_acc = push & (~full | pop_acc). When full, a simultaneous push+pop is accepted; count stays DEPTH and full stays 1.
- push+pop when empty: pop rejected (underflow set), push accepted, count -> 1. No bypass: the pushed word appears on read_data the next cycle.
- Accepted push writes mem[wr_ptr] <= write_data and advances wr_ptr.
- Accepted pop advances rd_ptr.
- count_next = count + push_acc - pop_acc. All status flags are derived combinationally from the registered count, so they take effect the cycle after the edge.
- read_data = mem[rd_ptr] when ~empty, else 0.
- Latency: a word pushed at edge N is visible on read_data after edge N if the FIFO was empty. A pop at edge N shows the next entry after edge N.
- overflow sets on push & ~push_acc. underflow sets on pop & ~pop_acc.
- Error flags hold until err_clr or rst. If err_clr and a new error occur in the same cycle, set wins.
- flush (priority over push/pop): pointers and count -> 0 at the next edge. Push/pop that cycle are ignored and do not set error flags. Error flags are unaffected by flush.
- Parameter legality is checked by elaboration-time assertions: DEPTH>=2, 1<=AF_THRESH<=DEPTH, 0<=AE_THRESH<DEPTH.

Test Plan:
- Reset/fill (DW=16, DEPTH=5, AF=4, AE=1): push 0x0001..0x0005 on consecutive cycles -> count 1..5; almost_empty drops when count=2; almost_full rises at count=4; full=1 at count=5. Pop all -> data 0x0001..0x0005 in order, empty=1.
- Wrap-around: with DEPTH=5, run 12 interleaved push/pop pairs of incrementing data -> output order intact across pointer wrap 4->0; count never exceeds 2.
- Full + simultaneous push/pop: at count=5, push 0xAAAA with pop -> 0x0001 consumed, count stays 5, full stays 1, overflow=0. The last pop of the stream returns 0xAAAA.
- Errors: push when full without pop -> overflow=1, count=5, contents unchanged. Pop when empty -> underflow=1, read_data=0. err_clr -> both 0 next cycle. err_clr together with a new overflow -> overflow stays 1.
- Flush: fill to 3, assert flush together with push -> next cycle count=0, empty=1, no write, error flags unchanged. A subsequent push of 0x1234 reads back as 0x1234.
- Async reset mid-stream: assert rst between clock edges at count=4 -> count=0, empty=1, overflow/underflow=0 immediately, before the next clk edge.
